adc_serial_responder: RTL

Serial-ADC responder that answers the frame issued by the ADC serial-interface master: it samples the master's chip-select, serial clock and command bits, decodes the start/mode/channel command, and returns an 8-bit conversion result MSB-first on the data line the master reads back. It stands in for the external converter in system simulation and on-board loopback, with conversion values supplied by logic through two parallel sample inputs.

---
 rtl/adc_serial_responder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/adc_serial_responder.sv
// Serial-ADC responder: decodes the start/sgl/odd command from the master and
// returns a null bit followed by a DATA_W-bit conversion word, MSB first.
module adc_serial_responder #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cs,
  input  logic              sclk,
  input  logic              din,
  input  logic [DATA_W-1:0] sample_ch0,
  input  logic [DATA_W-1:0] sample_ch1,
  output logic              dout,
  output logic              doe,
  output logic              busy,
  output logic              cfg_sgl,
  output logic              cfg_odd,
  output logic              frame_done
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W);

  typedef enum logic [2:0] {IDLE, CFG, SETTLE, SHIFT, DONE} state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  cs_sync, sclk_sync, din_sync;
  logic                    cs_d, sclk_d;
  logic                    cs_s, sclk_s, din_s;
  logic                    cs_rise, sclk_rise, sclk_fall;
  logic [CW-1:0]           bit_cnt;
  logic [DATA_W-1:0]       shreg;
  logic                    sgl_r;

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign din_s     = din_sync[SYNC_STAGES-1];
  assign cs_rise   = cs_s & ~cs_d;
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;

  // NOTE: cs synchronizer resets to the deasserted level so a low cs must
  // propagate through every stage again after reset before a frame can start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cs_sync   <= '1;
      sclk_sync <= '0;
      din_sync  <= '0;
      cs_d      <= 1'b1;
      sclk_d    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      din_sync  <= {din_sync[SYNC_STAGES-2:0], din};
      cs_d      <= cs_s;
      sclk_d    <= sclk_s;
    end
  end

  // NOTE: all state and outputs use non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      sgl_r      <= 1'b0;
      dout       <= 1'b0;
      doe        <= 1'b0;
      busy       <= 1'b0;
      cfg_sgl    <= 1'b0;
      cfg_odd    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (cs_rise) begin
        // Chip-select release aborts any frame; it outranks a same-cycle sclk edge.
        state   <= IDLE;
        bit_cnt <= '0;
        dout    <= 1'b0;
        doe     <= 1'b0;
        busy    <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (!cs_s && sclk_rise && din_s) begin
              state   <= CFG;
              bit_cnt <= '0;
              busy    <= 1'b1;
            end
          end
          CFG: begin
            if (sclk_rise) begin
              if (bit_cnt == '0) begin
                sgl_r   <= din_s;
                bit_cnt <= CW'(1);
              end else begin
                cfg_sgl <= sgl_r;
                cfg_odd <= din_s;
                shreg   <= din_s ? sample_ch1 : sample_ch0;
                bit_cnt <= '0;
                state   <= SETTLE;
              end
            end
          end
          SETTLE: begin
            if (sclk_fall) begin
              dout  <= 1'b0;
              doe   <= 1'b1;
              state <= SHIFT;
            end
          end
          SHIFT: begin
            if (sclk_fall) begin
              if (bit_cnt == LAST_BIT) begin
                dout       <= 1'b0;
                frame_done <= 1'b1;
                state      <= DONE;
              end else begin
                dout    <= shreg[DATA_W-1];
                shreg   <= shreg << 1;
                bit_cnt <= bit_cnt + CW'(1);
              end
            end
          end
          DONE: begin
            dout <= 1'b0;
            doe  <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
